divu_hilo: RTL and testbench

Downstream execute-stage unit that consumes the divide and HI/LO-select decode from the ALU control unit. It performs the multi-cycle `divu` instruction as a restoring divider, one quotient bit per cycle. It holds the HI/LO architectural registers and returns HI or LO for `mfhi`/`mflo`. While a divide is in flight, it stalls any instruction that needs the result or the divider.

---
 rtl/divu_hilo_if.sv | 13 +
 rtl/divu_hilo.sv | 63 ++++++
 tb/tb_divu_hilo.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/divu_hilo_if.sv
// divu_hilo_if: EX-stage divide request, HI/LO select and divider status bundle
interface divu_hilo_if #(parameter int WIDTH = 32);
  logic             Divu;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [1:0]       sel;
  logic [WIDTH-1:0] hilo_out;
  logic             busy;
  logic             stall;
  logic             done;
  modport master (output Divu, dividend, divisor, sel, input hilo_out, busy, stall, done);
  modport slave  (input Divu, dividend, divisor, sel, output hilo_out, busy, stall, done);
endinterface

// File: rtl/divu_hilo.sv
// divu_hilo: restoring unsigned divider (one quotient bit per cycle) owning the HI/LO registers
module divu_hilo #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  divu_hilo_if.slave  bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state, state_nxt;
  logic [WIDTH-1:0] hi, lo, rem, quo, dvs;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [CW-1:0]    count;
  logic             done_r;
  logic [WIDTH:0]   shifted, trial;
  logic             last;
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};
  assign rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};
  assign last    = count == CW'(WIDTH - 1);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  // accept a start only when idle; leave after the final iteration
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? (bus.Divu ? BUSY : IDLE) : (last ? IDLE : BUSY);
  end
  // divider datapath and HI/LO commit on the last iteration
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hi     <= '0;
      lo     <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      count  <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= (state == BUSY) && last;
      if (state == IDLE && bus.Divu) begin
        quo   <= bus.dividend;
        dvs   <= bus.divisor;
        rem   <= '0;
        count <= '0;
      end else if (state == BUSY) begin
        rem   <= rem_nxt;
        quo   <= quo_nxt;
        count <= count + 1'b1;
        if (last) begin
          hi <= rem_nxt;
          lo <= quo_nxt;
        end
      end
    end
  assign bus.busy     = state == BUSY;
  assign bus.done     = done_r;
  assign bus.stall    = bus.busy & (bus.Divu | bus.sel[1]);
  assign bus.hilo_out = (bus.sel == 2'b10) ? hi : (bus.sel == 2'b11) ? lo : '0;
endmodule

// File: tb/tb_divu_hilo.sv
// tb_divu_hilo: randomized scoreboard bench for divu_hilo against an arithmetic reference
module tb_divu_hilo;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  divu_hilo_if #(.WIDTH(32)) bus ();
  divu_hilo dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [63:0] q[$];
  int          left = 0;
  logic        m_done = 1'b0;
  logic [31:0] mhi = 0, mlo = 0;
  function automatic logic [63:0] golden(logic [31:0] a, logic [31:0] b);
    return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  // reference: a request is accepted only when no divide is outstanding; result appears 32 edges later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left   = 0;
      m_done = 1'b0;
      q.delete();
    end else begin
      automatic bit idle = (left == 0);
      m_done = 1'b0;
      if (left > 0) begin
        left--;
        if (left == 0) m_done = 1'b1;
      end
      if (idle && bus.Divu) begin
        q.push_back(golden(bus.dividend, bus.divisor));
        left = 32;
      end
    end
  end
  // monitor: pop the expected result whenever the DUT reports completion, check outputs every cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      mhi = 0;
      mlo = 0;
    end else begin
      if (bus.done === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_without_request: got done=1 expected no completion at %0t", $time);
        end else begin
          automatic logic [63:0] e = q.pop_front();
          mhi = e[63:32];
          mlo = e[31:0];
        end
      end
      chk("done", 32'(bus.done), 32'(m_done));
      chk("busy", 32'(bus.busy), 32'(left > 0));
      chk("stall", 32'(bus.stall), 32'((left > 0) && (bus.Divu || bus.sel[1])));
      chk("hilo_out", bus.hilo_out, (bus.sel == 2'b10) ? mhi : (bus.sel == 2'b11) ? mlo : 32'h0);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start(logic [31:0] a, logic [31:0] b);
    tick();
    bus.Divu     = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.Divu     = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
  endtask
  task automatic wait_done();
    int n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 32'(bus.done), 32'd1);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.Divu = 1'b0;
    bus.dividend = 0;
    bus.divisor = 0;
    bus.sel = 2'b11;
    #1;
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_lo", bus.hilo_out, 0);
    bus.sel = 2'b10;
    #1;
    chk("reset_hi", bus.hilo_out, 0);
    tick();
    rst_n = 1'b1;
    bus.sel = 2'b00;
    start(100, 7);
    wait_done();
    tick();
    bus.sel = 2'b11;
    #1;
    chk("lo_100_7", bus.hilo_out, 14);
    bus.sel = 2'b10;
    #1;
    chk("hi_100_7", bus.hilo_out, 2);
    start(32'hFFFF_FFFF, 1);
    wait_done();
    start(5, 32'h10);
    wait_done();
    start(32'h1234_5678, 0);
    wait_done();
    tick();
    bus.sel = 2'b11;
    #1;
    chk("lo_div0", bus.hilo_out, 32'hFFFF_FFFF);
    bus.sel = 2'b10;
    #1;
    chk("hi_div0", bus.hilo_out, 32'h1234_5678);
    bus.sel = 2'b00;
    start(1000, 3);
    tick();
    bus.sel = 2'b10;
    repeat (3) tick();
    bus.sel = 2'b00;
    #1;
    chk("flow_sel00", 32'(bus.stall), 0);
    tick();
    bus.sel = 2'b10;
    wait_done();
    chk("hi_done_cycle", bus.hilo_out, 1);
    chk("stall_done_cycle", 32'(bus.stall), 0);
    tick();
    bus.sel = 2'b00;
    start(50, 5);
    repeat (8) tick();
    bus.Divu = 1'b1;
    bus.dividend = 9;
    bus.divisor = 2;
    bus.sel = 2'b11;
    #1;
    chk("stall_held_divu", 32'(bus.stall), 1);
    wait_done();
    chk("lo_50_5", bus.hilo_out, 10);
    tick();
    bus.Divu = 1'b0;
    wait_done();
    chk("lo_9_2", bus.hilo_out, 4);
    tick();
    bus.sel = 2'b10;
    #1;
    chk("hi_9_2", bus.hilo_out, 1);
    start(77, 7);
    repeat (13) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_done", 32'(bus.done), 0);
    chk("arst_hi", bus.hilo_out, 0);
    bus.sel = 2'b11;
    #1;
    chk("arst_lo", bus.hilo_out, 0);
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_after_reset", 32'(bus.busy), 0);
    for (int i = 0; i < 2500; i++) begin
      tick();
      bus.Divu     = ($urandom % 6) == 0;
      bus.dividend = ($urandom % 2) ? $urandom : $urandom % 1000;
      bus.divisor  = ($urandom % 8 == 0) ? 0 : ($urandom % 2) ? $urandom : $urandom % 100;
      bus.sel      = 2'($urandom % 4);
    end
    tick();
    bus.Divu = 1'b0;
    for (int i = 0; i < 40 && bus.busy; i++) tick();
    repeat (3) tick();
    chk("drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
